multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/instr_decode.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the multicycle controller.
// Opcodes, ALU operations, FSM states and decoded instruction classes.
package cpu_pkg;

   localparam int DEF_PC_W = 12;
   localparam int DEF_IW   = 16;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ALU   = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_JMP   = 4'h4;
   localparam logic [3:0] OP_JN    = 4'h5;
   localparam logic [3:0] OP_JZ    = 4'h6;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] ALU_PASS_A = 3'd0;
   localparam logic [2:0] ALU_ADD    = 3'd1;
   localparam logic [2:0] ALU_INV    = 3'd2;
   localparam logic [2:0] ALU_AND    = 3'd3;
   localparam logic [2:0] ALU_SHL    = 3'd4;
   localparam logic [2:0] ALU_ASHR   = 3'd5;
   localparam logic [2:0] ALU_PASS_B = 3'd7;

   typedef enum logic [2:0] {
      S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_ALU, C_LOAD, C_STORE, C_JMP, C_JN, C_JZ, C_HALT
   } op_class_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: opcode class plus field extraction.
// Unknown opcodes fall into the NOP class.
module instr_decode
   import cpu_pkg::*;
#(
   parameter int IW   = DEF_IW,
   parameter int PC_W = DEF_PC_W
) (
   input  logic [IW-1:0]   ir,
   output op_class_t       cls,
   output logic [2:0]      alu_op,
   output logic [1:0]      ra,
   output logic [1:0]      rb,
   output logic [1:0]      r,
   output logic [PC_W-1:0] addr,
   output logic [PC_W-1:0] target
);

   assign alu_op = ir[11:9];
   assign ra     = ir[8:7];
   assign rb     = ir[6:5];
   assign r      = ir[11:10];
   assign addr   = PC_W'(ir[9:0]);
   assign target = PC_W'(ir[11:0]);

   always_comb begin
      cls = C_NOP;
      case (ir[15:12])
         OP_ALU:   cls = C_ALU;
         OP_LOAD:  cls = C_LOAD;
         OP_STORE: cls = C_STORE;
         OP_JMP:   cls = C_JMP;
         OP_JN:    cls = C_JN;
         OP_JZ:    cls = C_JZ;
         OP_HALT:  cls = C_HALT;
         default:  cls = C_NOP;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC with MEMRD/WB for loads.
// All control outputs are decoded from the current state and the IR.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_W = DEF_PC_W,
   parameter int IW   = DEF_IW,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [IW-1:0]   MEM_Data,
   input  logic            N,
   input  logic            Z,
   output logic            MEM_Read,
   output logic            MEM_Write,
   output logic [PC_W-1:0] MEM_Addr,
   output logic            REGS_Read1,
   output logic            REGS_Read2,
   output logic            REGS_Write,
   output logic [1:0]      Addr1,
   output logic [1:0]      Addr2,
   output logic [2:0]      ALU_OP,
   output logic            WB_Sel,
   output logic [PC_W-1:0] PC,
   output logic            HALTED
);

   state_t          state;
   state_t          nxt;
   logic [IW-1:0]   ir;
   logic [PC_W-1:0] pc;
   logic            fn;
   logic            fz;

   op_class_t       cls;
   logic [2:0]      alu_op;
   logic [1:0]      ra;
   logic [1:0]      rb;
   logic [1:0]      r;
   logic [PC_W-1:0] addr;
   logic [PC_W-1:0] target;

   instr_decode #(.IW(IW), .PC_W(PC_W)) u_dec (
      .ir     (ir),
      .cls    (cls),
      .alu_op (alu_op),
      .ra     (ra),
      .rb     (rb),
      .r      (r),
      .addr   (addr),
      .target (target)
   );

   assign PC = pc;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_INIT;
         pc    <= RST_PC;
         ir    <= '0;
         fn    <= 1'b0;
         fz    <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            S_FETCH: begin
               ir <= MEM_Data;
               pc <= pc + PC_W'(1);
            end
            S_EXEC: begin
               case (cls)
                  C_ALU: begin
                     fn <= N;
                     fz <= Z;
                  end
                  C_JMP:   pc <= target;
                  C_JN:    if (fn) pc <= target;
                  C_JZ:    if (fz) pc <= target;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt        = state;
      MEM_Read   = 1'b0;
      MEM_Write  = 1'b0;
      MEM_Addr   = '0;
      REGS_Read1 = 1'b0;
      REGS_Read2 = 1'b0;
      REGS_Write = 1'b0;
      Addr1      = 2'd0;
      Addr2      = 2'd0;
      ALU_OP     = 3'd0;
      WB_Sel     = 1'b0;
      HALTED     = 1'b0;
      case (state)
         S_INIT: nxt = S_FETCH;
         S_FETCH: begin
            MEM_Read = 1'b1;
            MEM_Addr = pc;
            nxt      = S_DECODE;
         end
         S_DECODE: begin
            if (cls == C_LOAD)      nxt = S_MEMRD;
            else if (cls == C_HALT) nxt = S_HALT;
            else                    nxt = S_EXEC;
         end
         S_EXEC: begin
            nxt = S_FETCH;
            if (cls == C_ALU) begin
               REGS_Read1 = 1'b1;
               REGS_Read2 = 1'b1;
               REGS_Write = 1'b1;
               Addr1      = ra;
               Addr2      = rb;
               ALU_OP     = alu_op;
            end else if (cls == C_STORE) begin
               REGS_Read2 = 1'b1;
               Addr2      = r;
               MEM_Write  = 1'b1;
               MEM_Addr   = addr;
            end
         end
         S_MEMRD: begin
            MEM_Read = 1'b1;
            MEM_Addr = addr;
            nxt      = S_WB;
         end
         S_WB: begin
            MEM_Read   = 1'b1;
            MEM_Addr   = addr;
            REGS_Write = 1'b1;
            Addr2      = r;
            WB_Sel     = 1'b1;
            nxt        = S_FETCH;
         end
         S_HALT: HALTED = 1'b1;
         default: nxt = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl with a register-file and falling-edge memory model.
// Per-cycle expected outputs come from a hand-written trace table.
module tb_multicycle_ctrl;
   import cpu_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [15:0] MEM_Data = 16'h0000;
   logic        N;
   logic        Z;
   logic        MEM_Read;
   logic        MEM_Write;
   logic [11:0] MEM_Addr;
   logic        REGS_Read1;
   logic        REGS_Read2;
   logic        REGS_Write;
   logic [1:0]  Addr1;
   logic [1:0]  Addr2;
   logic [2:0]  ALU_OP;
   logic        WB_Sel;
   logic [11:0] PC;
   logic        HALTED;

   multicycle_ctrl dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .MEM_Data   (MEM_Data),
      .N          (N),
      .Z          (Z),
      .MEM_Read   (MEM_Read),
      .MEM_Write  (MEM_Write),
      .MEM_Addr   (MEM_Addr),
      .REGS_Read1 (REGS_Read1),
      .REGS_Read2 (REGS_Read2),
      .REGS_Write (REGS_Write),
      .Addr1      (Addr1),
      .Addr2      (Addr2),
      .ALU_OP     (ALU_OP),
      .WB_Sel     (WB_Sel),
      .PC         (PC),
      .HALTED     (HALTED)
   );

   always #5 CLK = ~CLK;

   logic [15:0] mem [4096];
   logic [15:0] regs [4];
   logic [15:0] alu_y;
   logic        poke_mem = 1'b0;
   logic        poke_reg = 1'b0;
   logic [11:0] poke_a = 12'h000;
   logic [15:0] poke_d = 16'h0000;

   function automatic logic [15:0] alu_f(logic [2:0] op, logic [15:0] a, logic [15:0] b);
      case (op)
         ALU_PASS_A: return a;
         ALU_ADD:    return a + b;
         ALU_INV:    return ~a;
         ALU_AND:    return a & b;
         ALU_SHL:    return a << 1;
         ALU_ASHR:   return {a[15], a[15:1]};
         ALU_PASS_B: return b;
         default:    return 16'h0000;
      endcase
   endfunction

   always_comb alu_y = alu_f(ALU_OP, regs[Addr1], regs[Addr2]);
   assign N = alu_y[15];
   assign Z = (alu_y == 16'h0000);

   always @(negedge CLK)
      if (MEM_Read) MEM_Data <= mem[MEM_Addr];

   always @(posedge CLK) begin
      if (poke_mem) mem[poke_a] <= poke_d;
      else if (MEM_Write) mem[MEM_Addr] <= regs[Addr2];
      if (poke_reg) regs[poke_a[1:0]] <= poke_d;
      else if (REGS_Write) regs[Addr2] <= WB_Sel ? MEM_Data : alu_y;
   end

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [11:0] ad;
      logic        r1;
      logic        r2;
      logic        rw;
      logic [1:0]  a1;
      logic [1:0]  a2;
      logic [2:0]  op;
      logic        wb;
      logic [11:0] pc;
      logic        h;
   } out_t;

   typedef struct {
      string name;
      out_t  exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t tbl [17];

   function automatic out_t mk(logic rd, logic wr, logic [11:0] ad,
                               logic r1, logic r2, logic rw,
                               logic [1:0] a1, logic [1:0] a2,
                               logic [2:0] op, logic wb,
                               logic [11:0] pc, logic h);
      return '{rd, wr, ad, r1, r2, rw, a1, a2, op, wb, pc, h};
   endfunction

   function automatic out_t fo(logic [11:0] pc);
      return mk(1'b1, 1'b0, pc, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, pc, 1'b0);
   endfunction

   function automatic out_t io(logic [11:0] pc);
      return mk(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, pc, 1'b0);
   endfunction

   function automatic out_t sample();
      return '{MEM_Read, MEM_Write, MEM_Addr, REGS_Read1, REGS_Read2,
               REGS_Write, Addr1, Addr2, ALU_OP, WB_Sel, PC, HALTED};
   endfunction

   task automatic check_out(string nm, out_t e);
      out_t a;
      a = sample();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, a, e);
      end
   endtask

   task automatic check_val(string nm, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, a, e);
      end
   endtask

   task automatic poke(logic is_reg, logic [11:0] a, logic [15:0] d);
      @(negedge CLK);
      poke_a = a;
      poke_d = d;
      poke_mem = !is_reg;
      poke_reg = is_reg;
      @(posedge CLK);
      #1;
      poke_mem = 1'b0;
      poke_reg = 1'b0;
   endtask

   task automatic release_rst();
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
   endtask

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic clear_regs();
      for (int i = 0; i < 4; i++) poke(1'b1, 12'(i), 16'h0000);
   endtask

   initial begin
      tbl[0]  = '{"init",       io(12'h000)};
      tbl[1]  = '{"fetch0",     fo(12'h000)};
      tbl[2]  = '{"dec_add",    io(12'h001)};
      tbl[3]  = '{"exec_add",   mk(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1,
                                   2'd2, 2'd0, 3'd1, 1'b0, 12'h001, 1'b0)};
      tbl[4]  = '{"fetch1",     fo(12'h001)};
      tbl[5]  = '{"dec_load",   io(12'h002)};
      tbl[6]  = '{"memrd",      mk(1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0,
                                   2'd0, 2'd0, 3'd0, 1'b0, 12'h002, 1'b0)};
      tbl[7]  = '{"wb",         mk(1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 1'b1,
                                   2'd0, 2'd1, 3'd0, 1'b1, 12'h002, 1'b0)};
      tbl[8]  = '{"fetch2",     fo(12'h002)};
      tbl[9]  = '{"dec_store",  io(12'h003)};
      tbl[10] = '{"exec_store", mk(1'b0, 1'b1, 12'h007, 1'b0, 1'b1, 1'b0,
                                   2'd0, 2'd1, 3'd0, 1'b0, 12'h003, 1'b0)};
      tbl[11] = '{"fetch3",     fo(12'h003)};
      tbl[12] = '{"dec_jz",     io(12'h004)};
      tbl[13] = '{"exec_jz",    io(12'h004)};
      tbl[14] = '{"fetch123",   fo(12'h123)};
      tbl[15] = '{"dec_halt",   io(12'h124)};
      tbl[16] = '{"halt",       mk(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0,
                                   2'd0, 2'd0, 3'd0, 1'b0, 12'h124, 1'b1)};

      // Program: ADD r0=r2+r0; LOAD r1,[5]; STORE r1,[7]; JZ 0x123; HALT
      poke(1'b0, 12'h000, 16'h1300);
      poke(1'b0, 12'h001, 16'h2405);
      poke(1'b0, 12'h002, 16'h3407);
      poke(1'b0, 12'h003, 16'h6123);
      poke(1'b0, 12'h004, 16'hF000);
      poke(1'b0, 12'h005, 16'hBEEF);
      poke(1'b0, 12'h007, 16'h0000);
      poke(1'b0, 12'h123, 16'hF000);
      poke(1'b0, 12'hFFF, 16'h0000);
      clear_regs();
      release_rst();
      for (int i = 0; i < 17; i++) begin
         if (i > 0) step();
         check_out(tbl[i].name, tbl[i].exp);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         check_out("halt_hold", tbl[16].exp);
      end
      check_val("r0_add", 32'(regs[0]), 32'h0000);
      check_val("r1_load", 32'(regs[1]), 32'hBEEF);
      check_val("mem7_store", 32'(mem[7]), 32'hBEEF);

      RST_N = 1'b0;
      #1;
      check_out("halt_async_rst", io(12'h000));

      // Same program with a non-zero ADD result: JZ falls through
      clear_regs();
      poke(1'b1, 12'h002, 16'h0001);
      release_rst();
      repeat (13) step();
      check_out("jz_not_taken", io(12'h004));
      step();
      check_out("fetch_after_jz", fo(12'h004));
      check_val("r0_add_one", 32'(regs[0]), 32'h0001);

      // PC wrap at 12'hFFF
      RST_N = 1'b0;
      poke(1'b0, 12'h000, 16'h4FFF);
      release_rst();
      repeat (3) step();
      check_out("exec_jmp", io(12'h001));
      step();
      check_out("fetch_fff", fo(12'hFFF));
      step();
      check_out("pc_wrap", io(12'h000));
      step();
      check_out("exec_nop", io(12'h000));
      step();
      check_out("fetch_wrapped", fo(12'h000));

      // Reset during WB of a LOAD, then confirm FZ was cleared
      RST_N = 1'b0;
      poke(1'b0, 12'h000, 16'h1300);
      clear_regs();
      release_rst();
      repeat (7) step();
      check_out("wb_before_rst", tbl[7].exp);
      RST_N = 1'b0;
      #1;
      check_out("wb_async_rst", io(12'h000));
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("no_rw_in_rst", 32'(REGS_Write), 32'h0);
      end
      check_val("r1_untouched", 32'(regs[1]), 32'h0000);
      poke(1'b0, 12'h000, 16'h6123);
      release_rst();
      repeat (3) step();
      check_out("jz_after_rst", io(12'h001));
      step();
      check_out("fz_cleared", fo(12'h001));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
